// File: rtl/rec2pol_pkg.sv
// Shared defaults, fixed-point constants and FSM encodings for the rec2pol CORDIC converter.
package rec2pol_pkg;

  typedef logic [31:0] word_t;

  localparam int NITER_DEF = 32;
  localparam int IW_DEF    = 34;

  localparam int MOD_FRAC = 16;
  localparam int ANG_FRAC = 24;

  localparam word_t ANG_90   = 32'h5A00_0000;
  localparam word_t INV_GAIN = 32'h9B74_EDA8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/rec2pol_atan_rom.sv
// Combinational arctangent table: round(atan(2^-i) * 180/pi * 2^24), i.e. 8.24 degrees.
module rec2pol_atan_rom
  import rec2pol_pkg::*;
(
  input  logic [4:0] idx_i,
  output word_t      atan_o
);

  // Table lookup; entries past i=30 round to zero.
  always_comb begin
    case (idx_i)
      5'd0:    atan_o = 32'h2D00_0000;
      5'd1:    atan_o = 32'h1A90_A732;
      5'd2:    atan_o = 32'h0E09_4740;
      5'd3:    atan_o = 32'h0720_0112;
      5'd4:    atan_o = 32'h0393_8AA6;
      5'd5:    atan_o = 32'h01CA_3795;
      5'd6:    atan_o = 32'h00E5_2A1B;
      5'd7:    atan_o = 32'h0072_96D8;
      5'd8:    atan_o = 32'h0039_4BA5;
      5'd9:    atan_o = 32'h001C_A5DA;
      5'd10:   atan_o = 32'h000E_52EE;
      5'd11:   atan_o = 32'h0007_2977;
      5'd12:   atan_o = 32'h0003_94BC;
      5'd13:   atan_o = 32'h0001_CA5E;
      5'd14:   atan_o = 32'h0000_E52F;
      5'd15:   atan_o = 32'h0000_7297;
      5'd16:   atan_o = 32'h0000_394C;
      5'd17:   atan_o = 32'h0000_1CA6;
      5'd18:   atan_o = 32'h0000_0E53;
      5'd19:   atan_o = 32'h0000_0729;
      5'd20:   atan_o = 32'h0000_0395;
      5'd21:   atan_o = 32'h0000_01CA;
      5'd22:   atan_o = 32'h0000_00E5;
      5'd23:   atan_o = 32'h0000_0073;
      5'd24:   atan_o = 32'h0000_0039;
      5'd25:   atan_o = 32'h0000_001D;
      5'd26:   atan_o = 32'h0000_000E;
      5'd27:   atan_o = 32'h0000_0007;
      5'd28:   atan_o = 32'h0000_0004;
      5'd29:   atan_o = 32'h0000_0002;
      5'd30:   atan_o = 32'h0000_0001;
      5'd31:   atan_o = 32'h0000_0000;
      default: atan_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/rec2pol_cordic.sv
// Iterative vectoring-mode CORDIC: (x, y) in 16.16 -> modulus 16.16 and angle 8.24 degrees.
// Define REC2POL_DONE_EN to add a one-cycle 'done' strobe on the result-update edge.
module rec2pol_cordic
  import rec2pol_pkg::*;
#(
  parameter int NITER = NITER_DEF,
  parameter int IW    = IW_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
`ifdef REC2POL_DONE_EN
  output logic        done,
`endif
  output logic [31:0] mod_res,
  output logic [31:0] angle_res
);

  localparam logic [4:0] ITER_LAST = 5'(NITER - 1);

  logic [1:0]            state_q, state_d;
  logic [4:0]            iter_q, iter_d;
  logic signed [IW-1:0]  x_q, x_d, y_q, y_d;
  word_t                 z_q, z_d;
  word_t                 mod_q, mod_d, ang_q, ang_d;
  word_t                 atan_s;
  logic signed [IW-1:0]  xin_s, yin_s, xsh_s, ysh_s;
  logic signed [IW+32:0] prod_s;
  logic signed [IW:0]    mod_full_s;
  word_t                 mod_sat_s;

  rec2pol_atan_rom u_atan_rom (
    .idx_i  (iter_q),
    .atan_o (atan_s)
  );

  assign xin_s = {{(IW-32){x_in[31]}}, x_in};
  assign yin_s = {{(IW-32){y_in[31]}}, y_in};
  assign xsh_s = x_q >>> iter_q;
  assign ysh_s = y_q >>> iter_q;

  // x_final stays non-negative, so the unsigned gain is applied as a positive signed operand.
  assign prod_s     = x_q * $signed({1'b0, INV_GAIN});
  assign mod_full_s = (IW+1)'(prod_s >>> 32);

  // Clamp moduli that no longer fit in signed 16.16.
  always_comb begin
    if (!mod_full_s[IW] && (|mod_full_s[IW-1:31])) begin
      mod_sat_s = 32'h7FFF_FFFF;
    end else begin
      mod_sat_s = mod_full_s[31:0];
    end
  end

  // Next state: start loads and pre-rotates into the right half-plane, then one micro-rotation per step.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mod_d   = mod_q;
    ang_d   = ang_q;
    if (start) begin
      state_d = ST_RUN;
      iter_d  = 5'd0;
      if (!x_in[31]) begin
        x_d = xin_s;
        y_d = yin_s;
        z_d = 32'h0000_0000;
      end else if (!y_in[31]) begin
        x_d = yin_s;
        y_d = -xin_s;
        z_d = ANG_90;
      end else begin
        x_d = -yin_s;
        y_d = xin_s;
        z_d = 32'h0000_0000 - ANG_90;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (!y_q[IW-1]) begin
            x_d = x_q + ysh_s;
            y_d = y_q - xsh_s;
            z_d = z_q + atan_s;
          end else begin
            x_d = x_q - ysh_s;
            y_d = y_q + xsh_s;
            z_d = z_q - atan_s;
          end
          if (iter_q == ITER_LAST) begin
            state_d = ST_OUT;
          end else begin
            iter_d = iter_q + 5'd1;
          end
        end
        ST_OUT: begin
          mod_d   = mod_sat_s;
          ang_d   = z_q;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and result registers: reset wins, otherwise advance only on enabled edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      iter_q  <= 5'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= 32'h0000_0000;
      mod_q   <= 32'h0000_0000;
      ang_q   <= 32'h0000_0000;
    end else if (enable) begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mod_q   <= mod_d;
      ang_q   <= ang_d;
    end
  end

  assign mod_res   = mod_q;
  assign angle_res = ang_q;

`ifdef REC2POL_DONE_EN
  logic done_q;

  // Strobe on the publishing edge; any other enabled edge, a start or reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_q <= 1'b0;
    end else if (enable) begin
      done_q <= (state_q == ST_OUT) && !start;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_rec2pol_cordic.sv
// Directed bench for rec2pol_cordic: expected results come from real-valued sqrt/atan2,
// are queued at start and checked at the fixed 34-enabled-edge latency.
module tb_rec2pol_cordic;

  typedef struct {
    string tag;
    real   mod;
    real   ang;
  } exp_t;

  localparam real PI      = 3.14159265358979323846;
  localparam int  LATENCY = 34;
  localparam real MOD_MAX = 2147483647.0 / 65536.0;

  logic        clock = 1'b0;
  logic        reset, enable, start;
  logic [31:0] x_in, y_in, mod_res, angle_res;
`ifdef REC2POL_DONE_EN
  logic        done;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  int   edges    = 0;
  real  atan_sum = 0.0;
  exp_t sb[$];
  exp_t last_exp;

  always #5 clock = ~clock;

  rec2pol_cordic dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
`ifdef REC2POL_DONE_EN
    .done      (done),
`endif
    .mod_res   (mod_res),
    .angle_res (angle_res)
  );

  function automatic logic [31:0] deg2raw(input real d);
    longint r;
    r = longint'(d * 16777216.0);
    return r[31:0];
  endfunction

  task automatic tick(input logic en);
    enable = en;
    @(posedge clock);
    #1;
    if (en) edges++;
  endtask

  task automatic check_exact(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want)
      else begin
        n_fail++;
        $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, want);
      end
  endtask

  task automatic check_res(input string tag, input exp_t e);
    real         mod_o, dmod, tol;
    int          dang;
    logic [31:0] ang_e;
    mod_o = real'($signed(mod_res)) / 65536.0;
    dmod  = (mod_o > e.mod) ? (mod_o - e.mod) : (e.mod - mod_o);
    tol   = e.mod * 1.0e-4 + 16.0 / 65536.0;
    ang_e = deg2raw(e.ang);
    dang  = $signed(angle_res - ang_e);
    if (dang < 0) dang = -dang;
    n_assert++;
    assert (dmod <= tol)
      else begin
        n_fail++;
        $error("FAIL %s mod_res: got 0x%08h (%f) want %f +/- %f", tag, mod_res, mod_o, e.mod, tol);
      end
    n_assert++;
    assert (dang <= 1678)
      else begin
        n_fail++;
        $error("FAIL %s angle_res: got 0x%08h want 0x%08h (%f deg) +/- 1678 lsb", tag, angle_res, ang_e, e.ang);
      end
  endtask

  // A new start cancels any conversion still in flight, so its expectation is dropped.
  task automatic start_conv(input string tag, input int xi, input int yi);
    exp_t e;
    x_in  = 32'(xi * 65536);
    y_in  = 32'(yi * 65536);
    e.tag = tag;
    e.mod = $sqrt(real'(xi) ** 2 + real'(yi) ** 2);
    if (e.mod > MOD_MAX) e.mod = MOD_MAX;
    e.ang = (xi == 0 && yi == 0) ? atan_sum : $atan2(real'(yi), real'(xi)) * 180.0 / PI;
    sb.delete();
    sb.push_back(e);
    edges = 0;
    start = 1'b1;
    tick(1'b1);
    start = 1'b0;
  endtask

  task automatic wait_result(input int pause_at, input int pause_len);
    exp_t e;
    bit   paused;
    paused = 1'b0;
    while (edges < LATENCY) begin
      if (edges == pause_at && !paused) begin
        paused = 1'b1;
        repeat (pause_len) tick(1'b0);
        check_res({sb[0].tag, " frozen"}, last_exp);
      end
      if (edges == 29 || edges == LATENCY - 1) check_res({sb[0].tag, " hold"}, last_exp);
      tick(1'b1);
    end
    e = sb.pop_front();
    check_res(e.tag, e);
    last_exp = e;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) atan_sum += $atan(2.0 ** (-i)) * 180.0 / PI;
    last_exp.tag = "reset";
    last_exp.mod = 0.0;
    last_exp.ang = 0.0;
    reset  = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
    x_in   = 32'h0000_0000;
    y_in   = 32'h0000_0000;
    repeat (3) tick(1'b1);
    reset = 1'b0;
    check_exact("reset mod_res", mod_res, 32'h0000_0000);
    check_exact("reset angle_res", angle_res, 32'h0000_0000);

    start_conv("q4 (60,-60)", 60, -60);        wait_result(-1, 0);
    start_conv("q2 (-30,30)", -30, 30);        wait_result(-1, 0);
    start_conv("axis (100,0)", 100, 0);        wait_result(-1, 0);
    start_conv("axis (0,50)", 0, 50);          wait_result(-1, 0);
    start_conv("q3 (-40,-30)", -40, -30);      wait_result(-1, 0);
    start_conv("pause mid (30,30)", 30, 30);   wait_result(12, 5);
    start_conv("pause out (-25,40)", -25, 40); wait_result(33, 3);

    start_conv("origin (0,0)", 0, 0);
    wait_result(-1, 0);
    check_exact("origin mod_res", mod_res, 32'h0000_0000);

    start_conv("sat (-32768,-32768)", -32768, -32768);
    wait_result(-1, 0);
    check_exact("sat mod_res", mod_res, 32'h7FFF_FFFF);

    // Reset on enabled edge 10 aborts the conversion and clears the outputs.
    start_conv("abort (50,20)", 50, 20);
    while (edges < 10) tick(1'b1);
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    sb.delete();
    last_exp.mod = 0.0;
    last_exp.ang = 0.0;
    check_exact("abort mod_res", mod_res, 32'h0000_0000);
    check_exact("abort angle_res", angle_res, 32'h0000_0000);
    repeat (40) tick(1'b1);
    check_exact("abort later mod_res", mod_res, 32'h0000_0000);
    check_exact("abort later angle_res", angle_res, 32'h0000_0000);
    start_conv("after reset (20,-50)", 20, -50);
    wait_result(-1, 0);

    // Second start at edge 5 supersedes the first; edge 29 is when the first would have landed.
    start_conv("b2b first (10,10)", 10, 10);
    while (edges < 5) tick(1'b1);
    start_conv("b2b second (-25,-60)", -25, -60);
    wait_result(-1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rec2pol_cordic.md
Name: rec2pol_cordic

Overview:
- Iterative CORDIC in vectoring mode: converts a rectangular point (x, y) into modulus and angle in degrees.
- One 32-bit input pair is accepted per conversion; one CORDIC micro-rotation is done per enabled clock.
- Sits as a standalone arithmetic co-processor; results stay held on the outputs until the next conversion.

Parameters:
- NITER, 32, number of micro-rotations (one per cycle, i = 0..NITER-1).
- IW, 34, internal x/y datapath width (two guard bits over the 32-bit input).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  clock enable; when 0, all state, including outputs, is frozen.
- start  in  1  one-cycle pulse; loads inputs and begins a conversion, sampled only while enable=1.
- x_in  in  32  signed two's complement, 16.16 fixed point.
- y_in  in  32  signed two's complement, 16.16 fixed point.
- mod_res  out  32  signed 16.16 modulus, gain-corrected.
- angle_res  out  32  signed 8.24 angle in degrees, two's complement.

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high, port reset.
- Reset: mod_res=0, angle_res=0, x/y/z registers=0, iteration counter idle. Reset has priority over enable and start. Reset mid-conversion aborts the conversion.
- Timing, all edges counted with enable=1:
  - Edge 0 (start=1): load and pre-rotate.
  - Edges 1..32: iterations i=0..31.
  - Edge 33: output registers update.
  - Results are valid after 34 enabled edges, including the start edge.
- Pre-rotation at load, angle z in 8.24 degrees:
  - x>=0: x'=x, y'=y, z=0.
  - x<0, y>=0: x'=y, y'=-x, z=+90 deg (0x5A000000).
  - x<0, y<0: x'=-y, y'=x, z=-90 deg.
  - Inputs are sign-extended to IW bits.
- Iteration i:
  - y>=0: x+=y>>>i; y-=x>>>i; z+=atan_i.
  - Otherwise: x-=y>>>i; y+=x>>>i; z-=atan_i.
  - All updates use the old values. Shifts are arithmetic.
- atan_i = round(atan(2^-i)*180/pi * 2^24); e.g. i=0 gives 0x2D000000 (45 deg).
- Output stage:
  - mod_res = (x_final * 0x9B74EDA8) >> 32, i.e. x_final * 1/K with K=1.6467602581.
  - mod_res saturates to 0x7FFFFFFF if the result exceeds the 16.16 range.
  - angle_res = low 32 bits of z.
- Angle range: [-128, 128) deg is representable. Angles outside it wrap modulo 256 deg; e.g. 135 deg reads as raw 0x87000000 (= -121 deg signed). This wrap is the required behaviour.
- Input (0,0): mod_res=0, angle_res = the accumulated z value. No exception is flagged.
- start while a conversion is running: the new inputs are loaded and the counter restarts.
- enable dropped mid-conversion: the conversion pauses and resumes when enable returns.
- Outputs change only at the final output edge or on reset.

Optional Feature:
- Macro: REC2POL_DONE_EN.
- Defined: adds output port done (1 bit).
  - done goes high for one enabled cycle at the edge where mod_res/angle_res update.
  - done is cleared by reset, by start, and by the following enabled edge.
- Undefined: no done port; the consumer relies on the fixed 34-enabled-cycle latency.

Decomposition:
- Shared package rec2pol_pkg holds:
  - NITER and IW defaults.
  - Fixed-point format constants (16 fractional bits for modulus, 24 for angle).
  - ANG_90 = 0x5A000000.
  - INV_GAIN = 0x9B74EDA8.
- One sub-module: rec2pol_atan_rom, a combinational lookup from index i (5 bits) to atan_i (32 bits).

Test Plan:
- Reset, then start with (60,-60) (x_in=0x003C0000, y_in=0xFFC40000). After 34 enabled edges: mod_res ~84.8528 (~0x0054DA5E, within 0.01%); angle_res ~-45 deg (~0xD3000000, within 1e-4 deg).
- (-30,30): mod_res ~42.4264 (~0x002A6D2F); angle_res raw ~0x87000000 (135 deg wrapped).
- (100,0): mod_res = 0x00640000 (+/-2 LSB); angle_res ~0. Also (0,50): angle ~90 deg (0x5A000000), mod ~50.
- Start (30,30), drop enable for 5 cycles mid-run, then re-enable: results identical to an uninterrupted run (mod ~42.4264, angle ~45 deg, 0x2D000000); outputs frozen while enable=0.
- Assert reset at enabled edge 10 of a conversion: outputs read 0 and stay 0; a following start converts normally.
- Back-to-back starts: a second start at edge 5 yields only the second input's results, at 34 enabled edges after the second start.
